// File: rtl/ob_pkg.sv
// ob_pkg
//  Shared constants for the object-processor phrase buffer.
//  OB_PHRASE_W   : phrase data width in bits
//  OB_FIFO_DEPTH : number of phrase FIFO entries (power of 2, >=2)
//  OB_FIFO_AW    : log2(OB_FIFO_DEPTH)
package ob_pkg;
  localparam int OB_PHRASE_W   = 64;
  localparam int OB_FIFO_DEPTH = 4;
  localparam int OB_FIFO_AW    = 2;
endpackage

// File: rtl/ob_phrase_ram.sv
// ob_phrase_ram
//  DEPTH x DW register array used as phrase storage: one synchronous write port,
//  one asynchronous read port so the FIFO head is visible without a read cycle.
//  Ports:
//   sys_clk  in   system clock
//   we       in   write enable
//   waddr    in   write address
//   wdata    in   write data
//   raddr    in   read address
//   rdata    out  read data (combinational)
module ob_phrase_ram #(
  parameter int DW    = 64,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          sys_clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge sys_clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ob_phrase_fifo.sv
// ob_phrase_fifo
//  Phrase fetch/buffer stage between the memory ack pipe and the OP decoder.
//  Issues one-cycle fetch strobes (latchd), captures din on latch, and holds
//  phrases in a show-ahead FIFO. A fetch is only issued when a slot is free
//  after accounting for the outstanding fetch, so acknowledged data always fits.
//  Ports:
//   sys_clk  in   system clock
//   resetl   in   synchronous active-low reset
//   req      in   OP wants phrases fetched (level)
//   latchd   out  fetch strobe to ack pipe (one-cycle pulse)
//   latch    in   ack-pipe data strobe, din valid
//   din      in   memory phrase data
//   flush    in   empty FIFO and discard in-flight fetch
//   dout     out  head phrase (0 when empty)
//   dvalid   out  FIFO non-empty
//   dready   in   OP pops head when dvalid & dready
//   count    out  occupied entries 0..DEPTH
//   pend     out  one fetch outstanding
//   ovf      out  sticky: latch arrived while full
module ob_phrase_fifo
  import ob_pkg::*;
#(
  parameter int DW    = OB_PHRASE_W,
  parameter int DEPTH = OB_FIFO_DEPTH,
  parameter int AW    = OB_FIFO_AW
) (
  input  logic          sys_clk,
  input  logic          resetl,
  input  logic          req,
  output logic          latchd,
  input  logic          latch,
  input  logic [DW-1:0] din,
  input  logic          flush,
  output logic [DW-1:0] dout,
  output logic          dvalid,
  input  logic          dready,
  output logic [AW:0]   count,
  output logic          pend,
  output logic          ovf
);

  localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_V   = (AW+1)'(1);

  logic [AW:0]   wptr_reg, rptr_reg;
  logic          pend_reg, discard_reg, latchd_reg, ovf_reg;
  logic [AW:0]   occ, occ_next, credit, credit_next;
  logic          full, not_empty, push, pop, ovf_set, pend_next, issue;
  logic [DW-1:0] rdata;

  // Pointers carry a wrap bit, so the difference is the occupancy directly.
  assign occ       = wptr_reg - rptr_reg;
  assign full      = (occ == DEPTH_V);
  assign not_empty = (occ != '0);

  assign pop  = not_empty & dready & ~flush;
  // A simultaneous pop frees the slot when full, so the push still lands.
  assign push = latch & ~discard_reg & ~flush & (~full | dready);
  assign ovf_set = latch & ~discard_reg & ~flush & full & ~dready;

  // A fetch counts as outstanding from the cycle its strobe is driven.
  assign pend   = pend_reg | latchd_reg;
  assign credit = DEPTH_V - occ - (AW+1)'(pend);

  // Strobe and ack in the same cycle leave the pending flag set.
  assign pend_next   = latchd_reg | (pend_reg & ~latch);
  assign occ_next    = occ + (AW+1)'(push) - (AW+1)'(pop);
  assign credit_next = DEPTH_V - occ_next - (AW+1)'(pend_next);

  // Only one fetch is tracked: while one is outstanding, the next may be issued
  // only on the cycle its ack arrives, and only if a slot remains afterwards.
  assign issue = req & ~flush & ~latchd_reg &
                 (pend_reg ? (latch & (credit_next != '0)) : (credit != '0));

  always_ff @(posedge sys_clk) begin
    if (!resetl) begin
      wptr_reg    <= '0;
      rptr_reg    <= '0;
      pend_reg    <= 1'b0;
      discard_reg <= 1'b0;
      latchd_reg  <= 1'b0;
      ovf_reg     <= 1'b0;
    end else begin
      latchd_reg <= issue;
      pend_reg   <= pend_next;
      if (flush) begin
        wptr_reg    <= '0;
        rptr_reg    <= '0;
        // Any fetch still in flight will be acked later; drop that ack.
        discard_reg <= latchd_reg | (pend_reg & ~latch);
      end else begin
        if (push) wptr_reg <= wptr_reg + ONE_V;
        if (pop)  rptr_reg <= rptr_reg + ONE_V;
        if (latch) discard_reg <= 1'b0;
      end
      if (ovf_set) ovf_reg <= 1'b1;
    end
  end

  ob_phrase_ram #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .sys_clk (sys_clk),
    .we      (push),
    .waddr   (wptr_reg[AW-1:0]),
    .wdata   (din),
    .raddr   (rptr_reg[AW-1:0]),
    .rdata   (rdata)
  );

  assign latchd = latchd_reg;
  assign ovf    = ovf_reg;
  assign count  = occ;
  assign dvalid = not_empty;
  assign dout   = not_empty ? rdata : '0;

endmodule

// File: tb/tb_ob_phrase_fifo.sv
module tb_ob_phrase_fifo;

  logic        sys_clk = 1'b0;
  logic        resetl;
  logic        req;
  logic        latchd;
  logic        latch;
  logic [63:0] din;
  logic        flush;
  logic [63:0] dout;
  logic        dvalid;
  logic        dready;
  logic [2:0]  count;
  logic        pend;
  logic        ovf;

  int n_checks = 0;
  int n_fail   = 0;

  ob_phrase_fifo dut (
    .sys_clk (sys_clk),
    .resetl  (resetl),
    .req     (req),
    .latchd  (latchd),
    .latch   (latch),
    .din     (din),
    .flush   (flush),
    .dout    (dout),
    .dvalid  (dvalid),
    .dready  (dready),
    .count   (count),
    .pend    (pend),
    .ovf     (ovf)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Issue one fetch and ack it two cycles after the strobe.
  task automatic fetch_one(input logic [63:0] d);
    req = 1'b1;
    tick();
    req = 1'b0;
    tick();
    latch = 1'b1;
    din   = d;
    tick();
    latch = 1'b0;
  endtask

  task automatic test_reset();
    resetl = 1'b0; req = 1'b1; latch = 1'b1; din = 64'h1234; flush = 1'b0; dready = 1'b0;
    tick(); tick(); tick();
    n_checks++; if (latchd !== 1'b0) begin n_fail++; $display("FAIL reset_latchd: got %b expected 0", latchd); end
    n_checks++; if (dvalid !== 1'b0) begin n_fail++; $display("FAIL reset_dvalid: got %b expected 0", dvalid); end
    n_checks++; if (dout !== 64'h0) begin n_fail++; $display("FAIL reset_dout: got %h expected 0", dout); end
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
    n_checks++; if (pend !== 1'b0) begin n_fail++; $display("FAIL reset_pend: got %b expected 0", pend); end
    resetl = 1'b1; req = 1'b0; latch = 1'b0;
    tick();
    $display("test_reset done");
  endtask

  task automatic test_single();
    req = 1'b1;
    tick();
    req = 1'b0;
    n_checks++; if (latchd !== 1'b1) begin n_fail++; $display("FAIL single_latchd: got %b expected 1", latchd); end
    n_checks++; if (pend !== 1'b1) begin n_fail++; $display("FAIL single_pend: got %b expected 1", pend); end
    tick();
    n_checks++; if (latchd !== 1'b0) begin n_fail++; $display("FAIL single_latchd_pulse: got %b expected 0", latchd); end
    tick(); tick();
    latch = 1'b1; din = 64'hA5A5_0001;
    n_checks++; if (dvalid !== 1'b0) begin n_fail++; $display("FAIL single_nobypass: got %b expected 0", dvalid); end
    tick();
    latch = 1'b0;
    n_checks++; if (dvalid !== 1'b1) begin n_fail++; $display("FAIL single_dvalid: got %b expected 1", dvalid); end
    n_checks++; if (dout !== 64'hA5A5_0001) begin n_fail++; $display("FAIL single_dout: got %h expected a5a50001", dout); end
    n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL single_count: got %0d expected 1", count); end
    n_checks++; if (pend !== 1'b0) begin n_fail++; $display("FAIL single_pend_clr: got %b expected 0", pend); end
    dready = 1'b1;
    tick();
    dready = 1'b0;
    n_checks++; if (dvalid !== 1'b0) begin n_fail++; $display("FAIL single_pop: got %b expected 0", dvalid); end
    $display("test_single done");
  endtask

  task automatic test_fill();
    int cyc, ack_at, pulses;
    cyc = 0; ack_at = -1; pulses = 0;
    req = 1'b1; dready = 1'b0;
    for (int c = 0; c < 40; c++) begin
      latch = (cyc == ack_at);
      din   = 64'hF000_0000 | 64'(cyc);
      tick(); cyc++;
      if (latchd) begin pulses++; ack_at = cyc + 2; end
    end
    latch = 1'b0;
    n_checks++; if (pulses !== 4) begin n_fail++; $display("FAIL fill_pulses: got %0d expected 4", pulses); end
    n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL fill_count: got %0d expected 4", count); end
    n_checks++; if (latchd !== 1'b0) begin n_fail++; $display("FAIL fill_latchd: got %b expected 0", latchd); end
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL fill_ovf: got %b expected 0", ovf); end
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      dready = (c == 0);
      latch  = (cyc == ack_at);
      tick(); cyc++;
      if (latchd) begin pulses++; ack_at = cyc + 2; end
    end
    latch = 1'b0; dready = 1'b0;
    n_checks++; if (pulses !== 1) begin n_fail++; $display("FAIL fill_refetch: got %0d expected 1", pulses); end
    n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL fill_refill: got %0d expected 4", count); end
    req = 1'b0; dready = 1'b1;
    tick(); tick(); tick(); tick();
    dready = 1'b0;
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL fill_drain: got %0d expected 0", count); end
    $display("test_fill done");
  endtask

  task automatic test_wrap();
    int cyc, ack_at, issued, sent, got;
    cyc = 0; ack_at = -1; issued = 0; sent = 0; got = 0;
    for (int c = 0; c < 120; c++) begin
      latch = (cyc == ack_at);
      if (latch) begin din = 64'(sent); sent++; end
      dready = c[0];
      req = (issued < 10);
      if (dvalid && dready) begin
        n_checks++;
        if (dout !== 64'(got)) begin n_fail++; $display("FAIL wrap_order: got %h expected %h", dout, 64'(got)); end
        got++;
      end
      tick(); cyc++;
      if (latchd) begin issued++; ack_at = cyc + 2; end
    end
    latch = 1'b0; dready = 1'b0; req = 1'b0;
    n_checks++; if (got !== 10) begin n_fail++; $display("FAIL wrap_count: got %0d expected 10", got); end
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL wrap_ovf: got %b expected 0", ovf); end
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL wrap_empty: got %0d expected 0", count); end
    $display("test_wrap done");
  endtask

  task automatic test_flush();
    fetch_one(64'h1);
    fetch_one(64'h2);
    req = 1'b1;
    tick();
    req = 1'b0;
    tick();
    n_checks++; if (pend !== 1'b1 || count !== 3'd2) begin n_fail++; $display("FAIL flush_pre: got pend=%b count=%0d expected pend=1 count=2", pend, count); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL flush_count: got %0d expected 0", count); end
    n_checks++; if (dvalid !== 1'b0) begin n_fail++; $display("FAIL flush_dvalid: got %b expected 0", dvalid); end
    latch = 1'b1; din = 64'hDEAD;
    tick();
    latch = 1'b0;
    n_checks++; if (pend !== 1'b0) begin n_fail++; $display("FAIL flush_pend: got %b expected 0", pend); end
    n_checks++; if (dvalid !== 1'b0) begin n_fail++; $display("FAIL flush_drop: got %b expected 0", dvalid); end
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL flush_ovf: got %b expected 0", ovf); end
    fetch_one(64'hBEEF);
    n_checks++; if (dout !== 64'hBEEF || count !== 3'd1) begin n_fail++; $display("FAIL flush_next: got dout=%h count=%0d expected beef 1", dout, count); end
    dready = 1'b1;
    tick();
    dready = 1'b0;
    $display("test_flush done");
  endtask

  task automatic test_overflow();
    logic [63:0] exp_d;
    for (int i = 0; i < 4; i++) fetch_one(64'h10 + 64'(i));
    latch = 1'b1; din = 64'h99;
    tick();
    latch = 1'b0;
    n_checks++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b expected 1", ovf); end
    n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL ovf_count: got %0d expected 4", count); end
    n_checks++; if (dout !== 64'h10) begin n_fail++; $display("FAIL ovf_head: got %h expected 10", dout); end
    latch = 1'b1; dready = 1'b1; din = 64'h14;
    tick();
    latch = 1'b0; dready = 1'b0;
    n_checks++; if (count !== 3'd4 || ovf !== 1'b1) begin n_fail++; $display("FAIL full_pushpop: got count=%0d ovf=%b expected 4 1", count, ovf); end
    dready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_d = 64'h11 + 64'(i);
      n_checks++; if (dout !== exp_d) begin n_fail++; $display("FAIL ovf_order: got %h expected %h", dout, exp_d); end
      tick();
    end
    dready = 1'b0;
    req = 1'b1;
    tick();
    req = 1'b0;
    n_checks++; if (latchd !== 1'b1) begin n_fail++; $display("FAIL same_latchd: got %b expected 1", latchd); end
    latch = 1'b1; din = 64'h77;
    tick();
    latch = 1'b0;
    n_checks++; if (pend !== 1'b1) begin n_fail++; $display("FAIL same_pend: got %b expected 1", pend); end
    n_checks++; if (count !== 3'd1 || latchd !== 1'b0) begin n_fail++; $display("FAIL same_push: got count=%0d latchd=%b expected 1 0", count, latchd); end
    resetl = 1'b0;
    tick();
    resetl = 1'b1;
    n_checks++; if (ovf !== 1'b0 || pend !== 1'b0 || count !== 3'd0) begin n_fail++; $display("FAIL rereset: got ovf=%b pend=%b count=%0d expected 0 0 0", ovf, pend, count); end
    $display("test_overflow done");
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_wrap();
    test_flush();
    test_overflow();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
